// File: rtl/chain_constraint_sequencer_pkg.sv
// Shared encodings for the rope frame controller: Q12.20 format constants and FSM state codes.
package chain_pkg;

    localparam int Q_WIDTH = 32;
    localparam int Q_FRAC  = 20;
    localparam logic [Q_WIDTH-1:0] FIX_ONE = 32'h00100000;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE   = 3'd0;
    localparam state_t ST_VERLET = 3'd1;
    localparam state_t ST_PIN    = 3'd2;
    localparam state_t ST_FETCH  = 3'd3;
    localparam state_t ST_CLAMP  = 3'd4;
    localparam state_t ST_DONE   = 3'd5;

endpackage

// File: rtl/chain_constraint_sequencer_axis_clamp.sv
// Single-axis distance clamp: limits cur to within +/-rest of prev, result saturated to 32-bit signed.
module axis_clamp
    import chain_pkg::*;
(
    input  logic [Q_WIDTH-1:0] prev,
    input  logic [Q_WIDTH-1:0] cur,
    input  logic [Q_WIDTH-1:0] rest,
    output logic [Q_WIDTH-1:0] corrected
);

    localparam logic signed [Q_WIDTH:0] SAT_MAX = {1'b0, 32'h7FFFFFFF};
    localparam logic signed [Q_WIDTH:0] SAT_MIN = {1'b1, 32'h80000000};

    logic signed [Q_WIDTH:0] prev_ext;
    logic signed [Q_WIDTH:0] rest_pos;
    logic signed [Q_WIDTH:0] rest_neg;
    logic signed [Q_WIDTH:0] d_raw;
    logic signed [Q_WIDTH:0] d_lim;
    logic signed [Q_WIDTH:0] sum;

    assign prev_ext = {prev[Q_WIDTH-1], prev};
    assign rest_pos = {rest[Q_WIDTH-1], rest};
    assign rest_neg = -rest_pos;
    assign d_raw    = {cur[Q_WIDTH-1], cur} - prev_ext;

    // Strict compares: a separation of exactly rest passes through untouched.
    always_comb begin
        d_lim = d_raw;
        if (d_raw > rest_pos) begin
            d_lim = rest_pos;
        end else if (d_raw < rest_neg) begin
            d_lim = rest_neg;
        end
    end

    assign sum = prev_ext + d_lim;

    always_comb begin
        corrected = sum[Q_WIDTH-1:0];
        if (sum > SAT_MAX) begin
            corrected = SAT_MAX[Q_WIDTH-1:0];
        end else if (sum < SAT_MIN) begin
            corrected = SAT_MIN[Q_WIDTH-1:0];
        end
    end

endmodule

// File: rtl/chain_constraint_sequencer.sv
// Verlet rope frame controller: one integrate strobe, then ITERS passes pinning node 0
// and clamping each following node against its corrected predecessor.
//
// state  | meaning
// IDLE   | waiting for start
// VERLET | broadcast integrate strobe, one cycle
// PIN    | write anchor to node 0
// FETCH  | node_sel=idx, node position sampled at end of cycle
// CLAMP  | write corrected position to node idx
// DONE   | one-cycle done pulse, counters cleared
module chain_constraint_sequencer
    import chain_pkg::*;
#(
    parameter int                 NODES    = 8,
    parameter int                 ITERS    = 2,
    parameter logic [Q_WIDTH-1:0] REST     = 32'h00A00000,
    parameter logic [Q_WIDTH-1:0] ANCHOR_X = 32'h0C800000,
    parameter logic [Q_WIDTH-1:0] ANCHOR_Y = 32'h00000000
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic [Q_WIDTH-1:0]         node_x,
    input  logic [Q_WIDTH-1:0]         node_y,
    output logic [$clog2(NODES)-1:0]   node_sel,
    output logic                       verlet_state,
    output logic [NODES-1:0]           fix_constraint_state,
    output logic [Q_WIDTH-1:0]         x_fix_constraint,
    output logic [Q_WIDTH-1:0]         y_fix_constraint,
    output logic                       busy,
    output logic                       done
);

    localparam int IDX_W  = $clog2(NODES);
    localparam int ITER_W = (ITERS > 1) ? $clog2(ITERS) : 1;
    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NODES - 1);
    localparam logic [ITER_W-1:0] LAST_ITER = ITER_W'(ITERS - 1);

    state_t              state;
    logic [IDX_W-1:0]    idx;
    logic [ITER_W-1:0]   iter;
    logic [Q_WIDTH-1:0]  prev_x;
    logic [Q_WIDTH-1:0]  prev_y;
    logic [Q_WIDTH-1:0]  corr_x;
    logic [Q_WIDTH-1:0]  corr_y;

    // The read port is combinational, so the clamp works directly on the fetched
    // value and the corrected result is registered straight into the write outputs.
    axis_clamp u_clamp_x (
        .prev      (prev_x),
        .cur       (node_x),
        .rest      (REST),
        .corrected (corr_x)
    );

    axis_clamp u_clamp_y (
        .prev      (prev_y),
        .cur       (node_y),
        .rest      (REST),
        .corrected (corr_y)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state                <= ST_IDLE;
            idx                  <= '0;
            iter                 <= '0;
            prev_x               <= '0;
            prev_y               <= '0;
            node_sel             <= '0;
            verlet_state         <= 1'b0;
            fix_constraint_state <= '0;
            x_fix_constraint     <= '0;
            y_fix_constraint     <= '0;
            busy                 <= 1'b0;
            done                 <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state        <= ST_VERLET;
                        verlet_state <= 1'b1;
                        busy         <= 1'b1;
                    end
                end
                ST_VERLET: begin
                    verlet_state         <= 1'b0;
                    state                <= ST_PIN;
                    fix_constraint_state <= NODES'(1);
                    x_fix_constraint     <= ANCHOR_X;
                    y_fix_constraint     <= ANCHOR_Y;
                    prev_x               <= ANCHOR_X;
                    prev_y               <= ANCHOR_Y;
                    idx                  <= IDX_W'(1);
                end
                ST_PIN: begin
                    fix_constraint_state <= '0;
                    node_sel             <= idx;
                    state                <= ST_FETCH;
                end
                ST_FETCH: begin
                    fix_constraint_state <= NODES'(1) << idx;
                    x_fix_constraint     <= corr_x;
                    y_fix_constraint     <= corr_y;
                    prev_x               <= corr_x;
                    prev_y               <= corr_y;
                    state                <= ST_CLAMP;
                end
                ST_CLAMP: begin
                    fix_constraint_state <= '0;
                    if (idx < LAST_IDX) begin
                        idx      <= idx + 1'b1;
                        node_sel <= idx + 1'b1;
                        state    <= ST_FETCH;
                    end else if (iter < LAST_ITER) begin
                        iter                 <= iter + 1'b1;
                        state                <= ST_PIN;
                        fix_constraint_state <= NODES'(1);
                        x_fix_constraint     <= ANCHOR_X;
                        y_fix_constraint     <= ANCHOR_Y;
                        prev_x               <= ANCHOR_X;
                        prev_y               <= ANCHOR_Y;
                        idx                  <= IDX_W'(1);
                    end else begin
                        state <= ST_DONE;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                    end
                end
                ST_DONE: begin
                    done  <= 1'b0;
                    iter  <= '0;
                    idx   <= '0;
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
